fpu_cmd_regbank: RTL and testbench

//  APB-side register bank for the FPU peripheral with queued operation.
//  - Software stages OP1/OP2/OPSEL, then rings a doorbell that snapshots them into a command FIFO.
//  - The FPU drains that FIFO via valid/ready; its results and flags land in a result FIFO.
//  - Software pops results by reading RESULT. Sits between the APB slave wrapper and the FPU core.

---
 rtl/fpu_cmd_regbank.sv | 253 +++++++++++++++++++++++++
 tb/tb_fpu_cmd_regbank.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_cmd_regbank.sv
// ============================================================================
//  Module   : fpu_cmd_regbank
//  Purpose  : APB-side register bank for the FPU with command and result FIFOs.
//             Optional interrupt logic is enabled by defining FPU_REGBANK_IRQ_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fpu_cmd_regbank #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 3,
    parameter int OPSEL_WIDTH = 3,
    parameter int CMD_DEPTH   = 4,
    parameter int RES_DEPTH   = 4
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic [ADDR_WIDTH-1:0]  register_addr,
    input  logic [DATA_WIDTH-1:0]  Wdata,
    input  logic                   enable_register,
    input  logic                   write_enable,
    input  logic                   read_enable,
    output logic [DATA_WIDTH-1:0]  data_register,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [DATA_WIDTH-1:0]  OP1,
    output logic [DATA_WIDTH-1:0]  OP2,
    output logic [OPSEL_WIDTH-1:0] OP_select,
    input  logic [DATA_WIDTH-1:0]  Result_Fpu,
    input  logic                   Result_FPU_valid,
    input  logic                   zero_flag,
    input  logic                   INF_flag,
    input  logic                   NAN_flag,
    output logic                   res_ready,
    output logic                   irq
);

    localparam int c_CPW = $clog2(CMD_DEPTH);
    localparam int c_CCW = c_CPW + 1;
    localparam int c_RPW = $clog2(RES_DEPTH);
    localparam int c_RCW = c_RPW + 1;
    localparam int c_REW = DATA_WIDTH + 3;

    localparam logic [ADDR_WIDTH-1:0] c_ADDR_OP1    = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_OP2    = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_OPSEL  = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_CTRL   = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_STATUS = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_RESULT = ADDR_WIDTH'(5);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_RFLAGS = ADDR_WIDTH'(6);
`ifdef FPU_REGBANK_IRQ_EN
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_IRQMSK = ADDR_WIDTH'(7);
`endif

    logic [DATA_WIDTH-1:0]  r_op1;
    logic [DATA_WIDTH-1:0]  r_op2;
    logic [OPSEL_WIDTH-1:0] r_opsel;

    logic [DATA_WIDTH-1:0]  r_cmd_op1 [CMD_DEPTH];
    logic [DATA_WIDTH-1:0]  r_cmd_op2 [CMD_DEPTH];
    logic [OPSEL_WIDTH-1:0] r_cmd_sel [CMD_DEPTH];
    logic [c_CPW-1:0]       r_cmd_wptr;
    logic [c_CPW-1:0]       r_cmd_rptr;
    logic [c_CCW-1:0]       r_cmd_cnt;

    logic [c_REW-1:0]       r_res_mem [RES_DEPTH];
    logic [c_RPW-1:0]       r_res_wptr;
    logic [c_RPW-1:0]       r_res_rptr;
    logic [c_RCW-1:0]       r_res_cnt;

    logic r_cmd_ovf;
    logic r_res_ovf;
    logic r_res_udf;

    logic w_wr, w_rd, w_ctrl_wr, w_flush, w_push_req, w_stat_clr;
    logic w_cmd_empty, w_cmd_full, w_cmd_pop, w_cmd_push, w_cmd_ovf_set;
    logic w_res_empty, w_res_full, w_res_rd, w_res_pop, w_res_push;
    logic w_res_ovf_set, w_res_udf_set;
    logic [c_REW-1:0]      w_res_head;
    logic [DATA_WIDTH-1:0] w_res_data;
    logic [2:0]            w_res_flags;
    logic [23:0]           w_status;

    // Access decode: a read is only a read when write_enable is low
    assign w_wr       = enable_register && write_enable;
    assign w_rd       = enable_register && read_enable && !write_enable;
    assign w_ctrl_wr  = w_wr && (register_addr == c_ADDR_CTRL);
    assign w_flush    = w_ctrl_wr && Wdata[1];
    assign w_push_req = w_ctrl_wr && Wdata[0] && !Wdata[1];
    assign w_stat_clr = w_wr && (register_addr == c_ADDR_STATUS);

    assign w_cmd_empty   = (r_cmd_cnt == '0);
    assign w_cmd_full    = (r_cmd_cnt == c_CCW'(CMD_DEPTH));
    assign w_cmd_pop     = !w_cmd_empty && cmd_ready && !w_flush;
    assign w_cmd_push    = w_push_req && (!w_cmd_full || w_cmd_pop);
    assign w_cmd_ovf_set = w_push_req && w_cmd_full && !w_cmd_pop;

    assign w_res_empty   = (r_res_cnt == '0);
    assign w_res_full    = (r_res_cnt == c_RCW'(RES_DEPTH));
    assign w_res_rd      = w_rd && (register_addr == c_ADDR_RESULT);
    assign w_res_pop     = w_res_rd && !w_res_empty && !w_flush;
    assign w_res_push    = Result_FPU_valid && !w_flush && (!w_res_full || w_res_pop);
    assign w_res_ovf_set = Result_FPU_valid && !w_flush && w_res_full && !w_res_pop;
    assign w_res_udf_set = w_res_rd && w_res_empty;

    assign w_res_head  = r_res_mem[r_res_rptr];
    assign w_res_data  = w_res_empty ? '0 : w_res_head[DATA_WIDTH-1:0];
    assign w_res_flags = w_res_empty ? 3'b000 : w_res_head[c_REW-1:DATA_WIDTH];

    assign cmd_valid = !w_cmd_empty;
    assign OP1       = w_cmd_empty ? '0 : r_cmd_op1[r_cmd_rptr];
    assign OP2       = w_cmd_empty ? '0 : r_cmd_op2[r_cmd_rptr];
    assign OP_select = w_cmd_empty ? '0 : r_cmd_sel[r_cmd_rptr];
    assign res_ready = !w_res_full;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_op1   <= '0;
            r_op2   <= '0;
            r_opsel <= '0;
        end else if (w_wr) begin
            case (register_addr)
                c_ADDR_OP1:   r_op1   <= Wdata;
                c_ADDR_OP2:   r_op2   <= Wdata;
                c_ADDR_OPSEL: r_opsel <= Wdata[OPSEL_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    // Sticky errors: a new event in the clearing cycle keeps the bit set
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_cmd_ovf <= 1'b0;
            r_res_ovf <= 1'b0;
            r_res_udf <= 1'b0;
        end else begin
            r_cmd_ovf <= (r_cmd_ovf && !(w_stat_clr && Wdata[4])) || w_cmd_ovf_set;
            r_res_ovf <= (r_res_ovf && !(w_stat_clr && Wdata[5])) || w_res_ovf_set;
            r_res_udf <= (r_res_udf && !(w_stat_clr && Wdata[6])) || w_res_udf_set;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_cmd_wptr <= '0;
            r_cmd_rptr <= '0;
            r_cmd_cnt  <= '0;
        end else if (w_flush) begin
            r_cmd_wptr <= '0;
            r_cmd_rptr <= '0;
            r_cmd_cnt  <= '0;
        end else begin
            if (w_cmd_push)
                r_cmd_wptr <= r_cmd_wptr + c_CPW'(1);
            if (w_cmd_pop)
                r_cmd_rptr <= r_cmd_rptr + c_CPW'(1);
            if (w_cmd_push && !w_cmd_pop)
                r_cmd_cnt <= r_cmd_cnt + c_CCW'(1);
            else if (!w_cmd_push && w_cmd_pop)
                r_cmd_cnt <= r_cmd_cnt - c_CCW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_res_wptr <= '0;
            r_res_rptr <= '0;
            r_res_cnt  <= '0;
        end else if (w_flush) begin
            r_res_wptr <= '0;
            r_res_rptr <= '0;
            r_res_cnt  <= '0;
        end else begin
            if (w_res_push)
                r_res_wptr <= r_res_wptr + c_RPW'(1);
            if (w_res_pop)
                r_res_rptr <= r_res_rptr + c_RPW'(1);
            if (w_res_push && !w_res_pop)
                r_res_cnt <= r_res_cnt + c_RCW'(1);
            else if (!w_res_push && w_res_pop)
                r_res_cnt <= r_res_cnt - c_RCW'(1);
        end
    end

    // FIFO storage needs no reset; empty FIFOs mask their outputs to zero
    always_ff @(posedge CLK) begin
        if (w_cmd_push) begin
            r_cmd_op1[r_cmd_wptr] <= r_op1;
            r_cmd_op2[r_cmd_wptr] <= r_op2;
            r_cmd_sel[r_cmd_wptr] <= r_opsel;
        end
        if (w_res_push)
            r_res_mem[r_res_wptr] <= {NAN_flag, INF_flag, zero_flag, Result_Fpu};
    end

    always_comb begin
        w_status        = '0;
        w_status[0]     = w_cmd_empty;
        w_status[1]     = w_cmd_full;
        w_status[2]     = w_res_empty;
        w_status[3]     = w_res_full;
        w_status[4]     = r_cmd_ovf;
        w_status[5]     = r_res_ovf;
        w_status[6]     = r_res_udf;
        w_status[15:8]  = 8'(r_cmd_cnt);
        w_status[23:16] = 8'(r_res_cnt);
    end

`ifdef FPU_REGBANK_IRQ_EN
    logic [3:0] r_irq_mask;
    logic       r_irq;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_irq_mask <= 4'b0000;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr && (register_addr == c_ADDR_IRQMSK))
                r_irq_mask <= Wdata[3:0];
            r_irq <= |(r_irq_mask & {r_res_udf, r_res_ovf, r_cmd_ovf, !w_res_empty});
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

    // Outside a genuine read the bus shows the result head without popping it
    always_comb begin
        data_register = '0;
        if (!w_rd) begin
            data_register = w_res_data;
        end else begin
            case (register_addr)
                c_ADDR_OP1:    data_register = r_op1;
                c_ADDR_OP2:    data_register = r_op2;
                c_ADDR_OPSEL:  data_register = DATA_WIDTH'(r_opsel);
                c_ADDR_STATUS: data_register = DATA_WIDTH'(w_status);
                c_ADDR_RESULT: data_register = w_res_data;
                c_ADDR_RFLAGS: data_register = DATA_WIDTH'({!w_res_empty, w_res_flags});
`ifdef FPU_REGBANK_IRQ_EN
                c_ADDR_IRQMSK: data_register = DATA_WIDTH'(r_irq_mask);
`endif
                default:       data_register = '0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fpu_cmd_regbank.sv
// ============================================================================
//  Module   : tb_fpu_cmd_regbank
//  Purpose  : Scoreboard bench for fpu_cmd_regbank (commands and read data).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fpu_cmd_regbank;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic [2:0]  register_addr = '0;
    logic [31:0] Wdata = '0;
    logic        enable_register = 1'b0;
    logic        write_enable = 1'b0;
    logic        read_enable = 1'b0;
    logic [31:0] data_register;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [31:0] OP1, OP2;
    logic [2:0]  OP_select;
    logic [31:0] Result_Fpu = '0;
    logic        Result_FPU_valid = 1'b0;
    logic        zero_flag = 1'b0, INF_flag = 1'b0, NAN_flag = 1'b0;
    logic        res_ready;
    logic        irq;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [2:0]  sel;
    } cmd_t;

    cmd_t        exp_cmd_q[$];
    logic [31:0] exp_rd_q[$];
    int          checks = 0;
    int          failures = 0;

    fpu_cmd_regbank dut (
        .CLK(CLK), .RSTN(RSTN),
        .register_addr(register_addr), .Wdata(Wdata),
        .enable_register(enable_register), .write_enable(write_enable),
        .read_enable(read_enable), .data_register(data_register),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .OP1(OP1), .OP2(OP2), .OP_select(OP_select),
        .Result_Fpu(Result_Fpu), .Result_FPU_valid(Result_FPU_valid),
        .zero_flag(zero_flag), .INF_flag(INF_flag), .NAN_flag(NAN_flag),
        .res_ready(res_ready), .irq(irq)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Monitor: compares every command handshake and every bus read
    always @(negedge CLK) begin
        if (RSTN) begin
            if (cmd_valid && cmd_ready) begin
                checks++;
                if (exp_cmd_q.size() == 0) begin
                    failures++;
                    $display("FAIL cmd_handshake unexpected op1=0x%08h op2=0x%08h sel=%0d", OP1, OP2, OP_select);
                end else begin
                    cmd_t e;
                    e = exp_cmd_q.pop_front();
                    if ({OP1, OP2, OP_select} !== e) begin
                        failures++;
                        $display("FAIL cmd_handshake actual=%h/%h/%0d expected=%h/%h/%0d",
                                 OP1, OP2, OP_select, e.op1, e.op2, e.sel);
                    end
                end
            end
            if (enable_register && read_enable && !write_enable) begin
                checks++;
                if (exp_rd_q.size() == 0) begin
                    failures++;
                    $display("FAIL bus_read unexpected addr=%0d data=0x%08h", register_addr, data_register);
                end else begin
                    logic [31:0] e;
                    e = exp_rd_q.pop_front();
                    if (data_register !== e) begin
                        failures++;
                        $display("FAIL bus_read addr=%0d actual=0x%08h expected=0x%08h", register_addr, data_register, e);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        register_addr = a; Wdata = d;
        enable_register = 1'b1; write_enable = 1'b1; read_enable = 1'b0;
        tick();
        enable_register = 1'b0; write_enable = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp);
        exp_rd_q.push_back(exp);
        register_addr = a;
        enable_register = 1'b1; read_enable = 1'b1; write_enable = 1'b0;
        tick();
        enable_register = 1'b0; read_enable = 1'b0;
    endtask

    task automatic inject(input logic [31:0] d, input logic [2:0] nan_inf_zero);
        Result_Fpu = d;
        {NAN_flag, INF_flag, zero_flag} = nan_inf_zero;
        Result_FPU_valid = 1'b1;
        tick();
        Result_FPU_valid = 1'b0;
        {NAN_flag, INF_flag, zero_flag} = 3'b000;
    endtask

    task automatic inject_and_read(input logic [31:0] d, input logic [31:0] exp);
        exp_rd_q.push_back(exp);
        Result_Fpu = d; Result_FPU_valid = 1'b1;
        register_addr = 3'd5;
        enable_register = 1'b1; read_enable = 1'b1; write_enable = 1'b0;
        tick();
        Result_FPU_valid = 1'b0;
        enable_register = 1'b0; read_enable = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        check("reset_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        check("reset_op1", OP1, 32'd0);
        check("reset_res_ready", {31'd0, res_ready}, 32'd1);
        RSTN = 1'b1;
        tick();
        rd(3'd4, 32'h0000_0005);
        rd(3'd0, 32'h0000_0000);

        // 1: single command with FPU ready
        wr(3'd0, 32'h3F80_0000);
        wr(3'd1, 32'h4000_0000);
        wr(3'd2, 32'h0000_0001);
        cmd_ready = 1'b1;
        exp_cmd_q.push_back('{32'h3F80_0000, 32'h4000_0000, 3'd1});
        wr(3'd3, 32'h1);
        tick();
        check("t1_cmd_drained", {31'd0, cmd_valid}, 32'd0);
        rd(3'd4, 32'h0000_0005);
        rd(3'd0, 32'h3F80_0000);
        rd(3'd2, 32'h0000_0001);
        rd(3'd3, 32'h0000_0000);

        // 2: overflow the command FIFO, clear, then drain in order
        cmd_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            wr(3'd0, 32'(i));
            if (i <= 4) exp_cmd_q.push_back('{32'(i), 32'h4000_0000, 3'd1});
            wr(3'd3, 32'h1);
        end
        rd(3'd4, 32'h0000_0416);
        wr(3'd4, 32'h10);
        rd(3'd4, 32'h0000_0406);
        cmd_ready = 1'b1;
        repeat (8) tick();
        cmd_ready = 1'b0;
        check("t2_cmd_queue_drained", 32'(exp_cmd_q.size()), 32'd0);

        // 3: result ordering, flags peek, underflow
        inject(32'hA, 3'b000);
        inject(32'hB, 3'b100);
        rd(3'd6, 32'h8);
        rd(3'd5, 32'hA);
        rd(3'd6, 32'hC);
        rd(3'd5, 32'hB);
        rd(3'd5, 32'h0);
        rd(3'd4, 32'h0000_0045);
        wr(3'd4, 32'h40);
        rd(3'd4, 32'h0000_0005);

        // 4: full result FIFO, capture with simultaneous pop, then overflow
        for (int i = 1; i <= 4; i++) inject(32'(i), 3'b000);
        check("t4_res_ready_full", {31'd0, res_ready}, 32'd0);
        rd(3'd4, 32'h0004_0009);
        inject_and_read(32'h5, 32'h1);
        rd(3'd4, 32'h0004_0009);
        inject(32'h6, 3'b000);
        rd(3'd4, 32'h0004_0029);
        for (int i = 2; i <= 5; i++) rd(3'd5, 32'(i));
        wr(3'd4, 32'h20);
        rd(3'd4, 32'h0000_0005);

        // 5: flush with push in the same write, sticky bits survive
        rd(3'd5, 32'h0);
        wr(3'd0, 32'h11);
        for (int i = 0; i < 3; i++) wr(3'd3, 32'h1);
        inject(32'h21, 3'b001);
        inject(32'h22, 3'b010);
        rd(3'd4, 32'h0002_0340);
        wr(3'd3, 32'h3);
        check("t5_cmd_valid_after_flush", {31'd0, cmd_valid}, 32'd0);
        rd(3'd4, 32'h0000_0045);
        rd(3'd0, 32'h0000_0011);
        rd(3'd6, 32'h0);
        cmd_ready = 1'b1;
        repeat (3) tick();
        cmd_ready = 1'b0;
        wr(3'd4, 32'h70);

`ifdef FPU_REGBANK_IRQ_EN
        // 6: interrupt on result non-empty
        wr(3'd7, 32'h1);
        rd(3'd7, 32'h1);
        inject(32'h77, 3'b000);
        check("t6_irq_not_yet", {31'd0, irq}, 32'd0);
        tick();
        check("t6_irq_set", {31'd0, irq}, 32'd1);
        rd(3'd5, 32'h77);
        tick();
        check("t6_irq_cleared", {31'd0, irq}, 32'd0);
`else
        wr(3'd7, 32'hF);
        rd(3'd7, 32'h0);
        inject(32'h77, 3'b000);
        tick();
        check("t6_irq_tied_low", {31'd0, irq}, 32'd0);
        rd(3'd5, 32'h77);
`endif

        repeat (3) tick();
        check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
